// File: rtl/if1_fetch_unit.sv
// if1_fetch_unit: fetch PC owner and ICache request issuer for the IF1 stage.
// Requests are issued in order under a shared credit limit: requests in flight
// plus buffered instructions never exceed BUF_DEPTH. Responses are matched to
// their PCs through a pending-PC FIFO. A redirect flushes the buffer and marks
// every in-flight response for discard.
module if1_fetch_unit #(
   parameter logic [31:0] PC_RST    = 32'h1C00_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        icache_req,
   output logic [31:0] icache_addr,
   input  logic        icache_ready,
   input  logic        icache_valid,
   input  logic [31:0] icache_inst,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        pre_redirect,
   input  logic [31:0] pre_target,
   input  logic        out_stall,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int             PW      = $clog2(BUF_DEPTH);
   localparam int             CW      = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW:0]    DEPTH_W = (CW+1)'(BUF_DEPTH);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] buf_count;
   logic [PW-1:0] buf_rd, buf_wr;
   logic [PW-1:0] pend_rd, pend_wr;
   logic [31:0]   buf_pc   [BUF_DEPTH];
   logic [31:0]   buf_inst [BUF_DEPTH];
   logic [31:0]   pend_pc  [BUF_DEPTH];

   logic          redirect;
   logic [31:0]   target;
   logic [CW:0]   credit_used;
   logic          accept;
   logic          resp;
   logic          buf_push;
   logic          buf_pop;

   // Redirect selection, credit check and per-cycle handshake decode.
   // NOTE: combinational logic uses blocking assignments and assigns every
   // output a value on every path, so no latch can be inferred.
   always_comb begin
      redirect    = ex_redirect | pre_redirect;
      target      = ex_redirect ? ex_target : pre_target;
      credit_used = {1'b0, outstanding} + {1'b0, buf_count};
      icache_req  = rst_n & ~redirect & (credit_used < DEPTH_W);
      accept      = icache_req & icache_ready;
      resp        = icache_valid & (outstanding != '0);
      buf_push    = resp & (drop_cnt == '0) & ~redirect;
      buf_pop     = out_valid & ~out_stall & ~redirect;
   end

   assign icache_addr = fetch_pc;
   assign out_valid   = (buf_count != '0);
   assign out_pc      = out_valid ? buf_pc[buf_rd]   : 32'd0;
   assign out_inst    = out_valid ? buf_inst[buf_rd] : 32'd0;

   // Control state: fetch PC, credit counters, discard counter, FIFO pointers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= PC_RST;
         outstanding <= '0;
         drop_cnt    <= '0;
         buf_count   <= '0;
         buf_rd      <= '0;
         buf_wr      <= '0;
         pend_rd     <= '0;
         pend_wr     <= '0;
      end else begin
         if (redirect)
            fetch_pc <= target;
         else if (accept)
            fetch_pc <= fetch_pc + 32'd4;

         if (accept) pend_wr <= pend_wr + 1'b1;
         if (resp)   pend_rd <= pend_rd + 1'b1;

         case ({accept, resp})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase

         // Every request still in flight after this cycle is stale; that count
         // already includes any discards left over from an earlier redirect.
         if (redirect)
            drop_cnt <= outstanding - CW'(resp);
         else if (resp && (drop_cnt != '0))
            drop_cnt <= drop_cnt - 1'b1;

         if (redirect) begin
            buf_count <= '0;
            buf_rd    <= '0;
            buf_wr    <= '0;
         end else begin
            if (buf_push) buf_wr <= buf_wr + 1'b1;
            if (buf_pop)  buf_rd <= buf_rd + 1'b1;
            case ({buf_push, buf_pop})
               2'b10:   buf_count <= buf_count + 1'b1;
               2'b01:   buf_count <= buf_count - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // FIFO storage writes for pending PCs and buffered {pc, inst} entries.
   // NOTE: storage arrays are not reset; counts and pointers are, and every
   // read is qualified by them.
   always_ff @(posedge clk) begin
      if (accept)
         pend_pc[pend_wr] <= fetch_pc;
      if (buf_push) begin
         buf_pc[buf_wr]   <= pend_pc[pend_rd];
         buf_inst[buf_wr] <= icache_inst;
      end
   end

endmodule

// File: tb/tb_if1_fetch_unit.sv
// tb_if1_fetch_unit: directed scenarios with a scoreboard of hand-computed
// {pc, inst} pairs, a 1-cycle ICache model and a monitor on delivered outputs.
module tb_if1_fetch_unit;

   localparam logic [31:0] PC_RST = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_ready = 1'b0;
   logic        icache_valid = 1'b0;
   logic [31:0] icache_inst = 32'd0;
   logic        ex_redirect = 1'b0;
   logic [31:0] ex_target = 32'd0;
   logic        pre_redirect = 1'b0;
   logic [31:0] pre_target = 32'd0;
   logic        out_stall = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   logic        resp_hold = 1'b0;
   logic        stray = 1'b0;
   logic        acc_now = 1'b0;
   logic [31:0] acc_addr = 32'd0;
   logic [31:0] resp_q [$];

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } out_t;
   out_t sb_q [$];

   int tests_run = 0;
   int tests_failed = 0;

   if1_fetch_unit #(.PC_RST(PC_RST), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .icache_req(icache_req), .icache_addr(icache_addr),
      .icache_ready(icache_ready), .icache_valid(icache_valid),
      .icache_inst(icache_inst),
      .ex_redirect(ex_redirect), .ex_target(ex_target),
      .pre_redirect(pre_redirect), .pre_target(pre_target),
      .out_stall(out_stall), .out_valid(out_valid),
      .out_pc(out_pc), .out_inst(out_inst)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Instruction word the ICache model returns for a given PC.
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'h0280_0000 ^ (pc << 8);
   endfunction

   // ICache model: capture the handshake that the next rising edge will accept.
   always @(negedge clk) begin
      acc_now  = icache_req && icache_ready;
      acc_addr = icache_addr;
   end

   // ICache model: answer each accepted request one cycle later, in order.
   always @(posedge clk) begin
      #2;
      if (acc_now) resp_q.push_back(acc_addr);
      if (!rst_n) resp_q.delete();
      if (stray) begin
         icache_valid = 1'b1;
         icache_inst  = 32'hDEAD_BEEF;
      end else if (!resp_hold && resp_q.size() > 0) begin
         icache_valid = 1'b1;
         icache_inst  = inst_of(resp_q.pop_front());
      end else begin
         icache_valid = 1'b0;
         icache_inst  = 32'd0;
      end
   end

   // Monitor: every instruction handed downstream must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && !out_stall && !ex_redirect && !pre_redirect) begin
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_unexpected: got pc %h inst %h, expected no output", out_pc, out_inst);
         end else begin
            out_t e;
            e = sb_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_inst", out_inst, e.inst);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic out_t ent(input logic [31:0] pc, input logic [31:0] inst);
      out_t e;
      e.pc = pc;
      e.inst = inst;
      return e;
   endfunction

   initial begin
      // Reset state
      step(); step(); sample();
      check("rst_req", 32'(icache_req), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_inst", out_inst, 32'd0);
      check("rst_addr", icache_addr, PC_RST);

      // Reset release with 1-cycle responses
      sb_q.push_back(ent(32'h1C00_0000, 32'h0280_0000));
      sb_q.push_back(ent(32'h1C00_0004, 32'h0280_0400));
      step(); rst_n = 1'b1; icache_ready = 1'b1; sample();
      check("t1_req0", 32'(icache_req), 32'd1);
      check("t1_addr0", icache_addr, 32'h1C00_0000);
      step(); sample();
      check("t1_req1", 32'(icache_req), 32'd1);
      check("t1_addr1", icache_addr, 32'h1C00_0004);
      check("t1_valid_c1", 32'(out_valid), 32'd0);
      step(); sample();
      check("t1_valid_c2", 32'(out_valid), 32'd1);
      check("t1_req_credit", 32'(icache_req), 32'd0);
      step(); icache_ready = 1'b0; sample();
      check("t1_valid_c3", 32'(out_valid), 32'd1);
      step(); sample();
      check("t1_valid_c4", 32'(out_valid), 32'd0);

      // Backpressure from a fresh reset
      sb_q.push_back(ent(32'h1C00_0000, 32'h0280_0000));
      sb_q.push_back(ent(32'h1C00_0004, 32'h0280_0400));
      step(); rst_n = 1'b0;
      step(); rst_n = 1'b1; icache_ready = 1'b1; out_stall = 1'b1; sample();
      check("t2_addr0", icache_addr, 32'h1C00_0000);
      step(); sample();
      check("t2_addr1", icache_addr, 32'h1C00_0004);
      step(); sample();
      check("t2_req_full_a", 32'(icache_req), 32'd0);
      check("t2_pc_a", out_pc, 32'h1C00_0000);
      step(); sample();
      check("t2_req_full_b", 32'(icache_req), 32'd0);
      check("t2_pc_b", out_pc, 32'h1C00_0000);
      step(); out_stall = 1'b0; sample();
      check("t2_req_drain", 32'(icache_req), 32'd0);
      step(); icache_ready = 1'b0; sample();
      check("t2_req_resume", 32'(icache_req), 32'd1);
      check("t2_addr_resume", icache_addr, 32'h1C00_0008);
      step(); sample();
      check("t2_empty", 32'(out_valid), 32'd0);

      // EX redirect with two requests in flight
      sb_q.push_back(ent(32'h1C00_0100, 32'h0281_0000));
      step(); resp_hold = 1'b1; icache_ready = 1'b1; sample();
      check("t3_addr0", icache_addr, 32'h1C00_0008);
      step(); sample();
      check("t3_addr1", icache_addr, 32'h1C00_000C);
      step(); ex_redirect = 1'b1; ex_target = 32'h1C00_0100; sample();
      check("t3_req_redir", 32'(icache_req), 32'd0);
      step(); ex_redirect = 1'b0; ex_target = 32'd0; resp_hold = 1'b0; sample();
      check("t3_addr_tgt", icache_addr, 32'h1C00_0100);
      check("t3_valid_after", 32'(out_valid), 32'd0);
      step(); sample();
      check("t3_req_tgt", 32'(icache_req), 32'd1);
      check("t3_addr_tgt2", icache_addr, 32'h1C00_0100);
      step(); icache_ready = 1'b0; sample();
      check("t3_valid_drop", 32'(out_valid), 32'd0);
      step(); sample();
      check("t3_valid_tgt", 32'(out_valid), 32'd1);
      step(); sample();
      check("t3_empty", 32'(out_valid), 32'd0);

      // Simultaneous EX and predictor redirects
      step(); ex_redirect = 1'b1; ex_target = 32'h1C00_0200;
      pre_redirect = 1'b1; pre_target = 32'h1C00_0300; sample();
      check("t4_req_redir", 32'(icache_req), 32'd0);
      step(); ex_redirect = 1'b0; pre_redirect = 1'b0; sample();
      check("t4_addr_ex", icache_addr, 32'h1C00_0200);
      check("t4_req", 32'(icache_req), 32'd1);

      // Redirect, response and stall in the same cycle
      sb_q.push_back(ent(32'h1C00_0400, 32'h0284_0000));
      step(); icache_ready = 1'b1; sample();
      check("t5_addr0", icache_addr, 32'h1C00_0200);
      step(); sample();
      check("t5_valid_c1", 32'(out_valid), 32'd0);
      step(); pre_redirect = 1'b1; pre_target = 32'h1C00_0400; out_stall = 1'b1;
      icache_ready = 1'b0; sample();
      check("t5_head_pc", out_pc, 32'h1C00_0200);
      check("t5_req_redir", 32'(icache_req), 32'd0);
      step(); pre_redirect = 1'b0; pre_target = 32'd0; out_stall = 1'b0; sample();
      check("t5_valid_clr", 32'(out_valid), 32'd0);
      check("t5_inst_clr", out_inst, 32'd0);
      check("t5_pc_clr", out_pc, 32'd0);
      check("t5_addr_tgt", icache_addr, 32'h1C00_0400);
      step(); icache_ready = 1'b1; sample();
      check("t5_req_tgt", 32'(icache_req), 32'd1);
      step(); icache_ready = 1'b0; sample();
      check("t5_valid_wait", 32'(out_valid), 32'd0);
      step(); sample();
      check("t5_valid_tgt", 32'(out_valid), 32'd1);

      // Reset with a full buffer, then a stray response
      step(); out_stall = 1'b1; icache_ready = 1'b1; sample();
      check("t6_addr0", icache_addr, 32'h1C00_0404);
      step(); sample();
      step(); icache_ready = 1'b0; sample();
      step(); sample();
      check("t6_full_valid", 32'(out_valid), 32'd1);
      check("t6_full_pc", out_pc, 32'h1C00_0404);
      check("t6_full_req", 32'(icache_req), 32'd0);
      step(); rst_n = 1'b0; sample();
      check("t6_rst_req", 32'(icache_req), 32'd0);
      sb_q.push_back(ent(32'h1C00_0000, 32'h0280_0000));
      step(); rst_n = 1'b1; out_stall = 1'b0; stray = 1'b1; sample();
      check("t6_valid_rst", 32'(out_valid), 32'd0);
      check("t6_addr_rst", icache_addr, PC_RST);
      step(); stray = 1'b0; icache_ready = 1'b1; sample();
      check("t6_stray_ign", 32'(out_valid), 32'd0);
      check("t6_restart", icache_addr, 32'h1C00_0000);
      check("t6_restart_req", 32'(icache_req), 32'd1);
      step(); icache_ready = 1'b0; sample();
      check("t6_valid_wait", 32'(out_valid), 32'd0);
      step(); sample();
      check("t6_valid_a0", 32'(out_valid), 32'd1);
      step(); sample();
      check("t6_empty", 32'(out_valid), 32'd0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
